// File: rtl/hba_timer.sv
// hba_timer: memory-mapped down-counting timer slave on the HBA bus.
//
// Ports:
//   hba_clk            sole clock, all logic on the rising edge
//   hba_reset          asynchronous active-low reset
//   hba_rnw            1 = read, 0 = write
//   hba_select         transfer in progress
//   hba_abus           {slot, register} address
//   hba_dbus           write data
//   hba_dbus_slave     read data, zero outside the ack cycle
//   hba_xferack_slave  one-cycle transfer acknowledge
//   slave_interrupt    level interrupt, EXP & IE (registered)
//
// Register map: 0 CTRL {IE,AUTO,EN}, 1 PRESCALE, 2 RELOAD, 3 COUNT (RO),
// 4 STATUS {EXP} (write 1 to clear); every other register reads 0.
module hba_timer #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int PERIPH_ADDR       = 0
) (
  input  logic                                        hba_clk,
  input  logic                                        hba_reset,
  input  logic                                        hba_rnw,
  input  logic                                        hba_select,
  input  logic [PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH-1:0] hba_abus,
  input  logic [DBUS_WIDTH-1:0]                       hba_dbus,
  output logic [DBUS_WIDTH-1:0]                       hba_dbus_slave,
  output logic                                        hba_xferack_slave,
  output logic                                        slave_interrupt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [REG_ADDR_WIDTH-1:0] REG_CTRL     = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_PRESCALE = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_RELOAD   = REG_ADDR_WIDTH'(2);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_COUNT    = REG_ADDR_WIDTH'(3);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_STATUS   = REG_ADDR_WIDTH'(4);

  logic [PERIPH_ADDR_WIDTH-1:0] slot;
  logic [REG_ADDR_WIDTH-1:0]    reg_addr;
  logic [7:0]                   wdata;

  assign slot     = hba_abus[PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH-1:REG_ADDR_WIDTH];
  assign reg_addr = hba_abus[REG_ADDR_WIDTH-1:0];
  assign wdata    = 8'(hba_dbus);

  logic [1:0]                state_q, state_d;
  logic                      rnw_q, rnw_d;
  logic [REG_ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                      en_q, en_d;
  logic                      auto_q, auto_d;
  logic                      ie_q, ie_d;
  logic [7:0]                prescale_q, prescale_d;
  logic [7:0]                reload_q, reload_d;
  logic [7:0]                count_q, count_d;
  logic [7:0]                pre_q, pre_d;
  logic                      exp_q, exp_d;
  logic                      irq_q, irq_d;

  logic accept;
  logic wr;
  logic tick;
  logic expire;
  logic [7:0] rdata;

  always_comb begin
    state_d    = state_q;
    rnw_d      = rnw_q;
    raddr_d    = raddr_q;
    en_d       = en_q;
    auto_d     = auto_q;
    ie_d       = ie_q;
    prescale_d = prescale_q;
    reload_d   = reload_q;
    count_d    = count_q;
    pre_d      = pre_q;
    exp_d      = exp_q;

    accept = (state_q == ST_IDLE) && hba_select &&
             (slot == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
    wr     = accept && !hba_rnw;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ACK;
          rnw_d   = hba_rnw;
          raddr_d = reg_addr;
        end
      end
      ST_ACK:  state_d = ST_HOLD;
      ST_HOLD: if (!hba_select) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Timer update first; bus writes below override it where they collide.
    tick   = en_q && (pre_q == prescale_q);
    expire = tick && (count_q == 8'd0);
    if (en_q) pre_d = tick ? 8'd0 : pre_q + 8'd1;
    if (tick) begin
      if (count_q != 8'd0) begin
        count_d = count_q - 8'd1;
      end else begin
        exp_d = 1'b1;
        if (auto_q) count_d = reload_q;
        else        en_d    = 1'b0;
      end
    end

    if (wr) begin
      case (reg_addr)
        REG_CTRL: begin
          en_d   = wdata[0];
          auto_d = wdata[1];
          ie_d   = wdata[2];
          if (!en_q && wdata[0]) begin
            count_d = reload_q;
            pre_d   = 8'd0;
          end
        end
        REG_PRESCALE: prescale_d = wdata;
        REG_RELOAD:   reload_d   = wdata;
        // An expiry in the same cycle keeps EXP set.
        REG_STATUS:   if (wdata[0] && !expire) exp_d = 1'b0;
        default: ;
      endcase
    end

    irq_d = exp_d & ie_d;
  end

  always_comb begin
    rdata = 8'd0;
    case (raddr_q)
      REG_CTRL:     rdata = {5'd0, ie_q, auto_q, en_q};
      REG_PRESCALE: rdata = prescale_q;
      REG_RELOAD:   rdata = reload_q;
      REG_COUNT:    rdata = count_q;
      REG_STATUS:   rdata = {7'd0, exp_q};
      default:      rdata = 8'd0;
    endcase
  end

  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) begin
      state_q    <= ST_IDLE;
      rnw_q      <= 1'b0;
      raddr_q    <= '0;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      ie_q       <= 1'b0;
      prescale_q <= '0;
      reload_q   <= '0;
      count_q    <= '0;
      pre_q      <= '0;
      exp_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rnw_q      <= rnw_d;
      raddr_q    <= raddr_d;
      en_q       <= en_d;
      auto_q     <= auto_d;
      ie_q       <= ie_d;
      prescale_q <= prescale_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      pre_q      <= pre_d;
      exp_q      <= exp_d;
      irq_q      <= irq_d;
    end
  end

  assign hba_xferack_slave = (state_q == ST_ACK);
  assign hba_dbus_slave    = (state_q == ST_ACK && rnw_q) ? DBUS_WIDTH'(rdata) : '0;
  assign slave_interrupt   = irq_q;

endmodule

// File: tb/tb_hba_timer.sv
// Directed bench for hba_timer: bus protocol, register map, timer periods,
// expiry/W1C collision and reset behaviour.
module tb_hba_timer;

  logic        hba_clk = 1'b0;
  logic        hba_reset = 1'b1;
  logic        hba_rnw = 1'b1;
  logic        hba_select = 1'b0;
  logic [11:0] hba_abus = '0;
  logic [7:0]  hba_dbus = '0;
  logic [7:0]  hba_dbus_slave;
  logic        hba_xferack_slave;
  logic        slave_interrupt;

  int total = 0;
  int passed = 0;
  int failed = 0;

  hba_timer #(
    .DBUS_WIDTH(8),
    .PERIPH_ADDR_WIDTH(4),
    .REG_ADDR_WIDTH(8),
    .PERIPH_ADDR(0)
  ) dut (
    .hba_clk(hba_clk),
    .hba_reset(hba_reset),
    .hba_rnw(hba_rnw),
    .hba_select(hba_select),
    .hba_abus(hba_abus),
    .hba_dbus(hba_dbus),
    .hba_dbus_slave(hba_dbus_slave),
    .hba_xferack_slave(hba_xferack_slave),
    .slave_interrupt(slave_interrupt)
  );

  always #5 hba_clk = ~hba_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge hba_clk);
    #1;
  endtask

  // Called at posedge+1. Select stays high for 'hold' edges, then two more
  // edges let the slave return to idle. Data and interrupt are captured in
  // the cycle after the first sampling edge.
  task automatic xfer(input logic rnw, input logic [3:0] slot, input logic [7:0] r,
                      input logic [7:0] wd, input int hold,
                      output logic [7:0] rdo, output int ack_n, output logic irq_first);
    hba_rnw    = rnw;
    hba_abus   = {slot, r};
    hba_dbus   = wd;
    hba_select = 1'b1;
    ack_n      = 0;
    rdo        = '0;
    irq_first  = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge hba_clk);
      #1;
      if (i == 0) begin
        rdo       = hba_dbus_slave;
        irq_first = slave_interrupt;
      end
      ack_n += int'(hba_xferack_slave);
    end
    hba_select = 1'b0;
    repeat (2) begin
      @(posedge hba_clk);
      #1;
      ack_n += int'(hba_xferack_slave);
    end
  endtask

  task automatic wr(input logic [7:0] r, input logic [7:0] wd);
    logic [7:0] d;
    int a;
    logic q;
    xfer(1'b0, 4'd0, r, wd, 1, d, a, q);
  endtask

  task automatic rdreg(input logic [7:0] r, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    int a;
    logic q;
    xfer(1'b1, 4'd0, r, 8'h00, 1, d, a, q);
    check({tag, "_data"}, d, exp);
    check({tag, "_acks"}, 8'(a), 8'd1);
  endtask

  initial begin
    logic [7:0] d;
    int a;
    logic q;

    // Reset and reset state
    #2 hba_reset = 1'b0;
    step(2);
    check("rst_ack", {7'd0, hba_xferack_slave}, 8'd0);
    check("rst_dbus", hba_dbus_slave, 8'd0);
    check("rst_irq", {7'd0, slave_interrupt}, 8'd0);
    hba_reset = 1'b1;
    rdreg(8'd0, 8'h00, "rst_ctrl");
    rdreg(8'd2, 8'h00, "rst_reload");
    rdreg(8'd4, 8'h00, "rst_status");
    rdreg(8'd3, 8'h00, "rst_count");

    // Register map, unmapped registers, foreign slot
    wr(8'd1, 8'h5A);
    rdreg(8'd1, 8'h5A, "prescale_rw");
    wr(8'd9, 8'hFF);
    rdreg(8'd7, 8'h00, "unmapped7");
    rdreg(8'd9, 8'h00, "unmapped9");
    xfer(1'b1, 4'd1, 8'd1, 8'h00, 1, d, a, q);
    check("other_slot_acks", 8'(a), 8'd0);
    check("other_slot_data", d, 8'h00);

    // Long select: one ack only, then a fresh ack after re-select
    xfer(1'b1, 4'd0, 8'd1, 8'h00, 5, d, a, q);
    check("hold_acks", 8'(a), 8'd1);
    check("hold_data", d, 8'h5A);
    xfer(1'b1, 4'd0, 8'd1, 8'h00, 1, d, a, q);
    check("reselect_acks", 8'(a), 8'd1);

    // Auto-reload: RELOAD=3, PRESCALE=0, CTRL=0x07 -> expiry every 4 clocks
    wr(8'd1, 8'h00);
    wr(8'd2, 8'h03);
    rdreg(8'd2, 8'h03, "reload_rw");
    wr(8'd0, 8'h07);                 // enable edge E0, now at E2+1
    step(1);
    check("auto_irq_e3", {7'd0, slave_interrupt}, 8'd0);
    step(1);
    check("auto_irq_e4", {7'd0, slave_interrupt}, 8'd1);
    wr(8'd4, 8'h01);                 // W1C at E5, now at E7+1
    check("w1c_clear", {7'd0, slave_interrupt}, 8'd0);
    step(1);
    check("auto_repeat_e8", {7'd0, slave_interrupt}, 8'd1);
    step(3);                         // E11+1
    xfer(1'b0, 4'd0, 8'd4, 8'h01, 1, d, a, q);   // W1C lands on expiry E12
    check("w1c_vs_expire", {7'd0, q}, 8'd1);
    check("w1c_vs_expire_late", {7'd0, slave_interrupt}, 8'd1);
    wr(8'd0, 8'h04);                 // stop, keep IE
    xfer(1'b0, 4'd0, 8'd4, 8'h01, 1, d, a, q);
    check("w1c_irq_fall", {7'd0, q}, 8'd0);
    rdreg(8'd4, 8'h00, "status_cleared");
    rdreg(8'd0, 8'h04, "ctrl_stopped");
    wr(8'd3, 8'h55);
    rdreg(8'd3, 8'h00, "count_ro");

    // One-shot: RELOAD=2, PRESCALE=1, CTRL=0x01
    wr(8'd2, 8'h02);
    wr(8'd1, 8'h01);
    wr(8'd0, 8'h01);                 // E0 enable, now at E2+1
    rdreg(8'd3, 8'h01, "count_running");   // sampled at E3
    step(2);
    rdreg(8'd4, 8'h01, "oneshot_exp");
    rdreg(8'd0, 8'h00, "oneshot_ctrl");
    rdreg(8'd3, 8'h00, "oneshot_count");

    // One-shot with IE: interrupt exactly 6 clocks after enable
    wr(8'd4, 8'h01);
    wr(8'd0, 8'h05);                 // E0 enable, now at E2+1
    step(3);
    check("oneshot_irq_e5", {7'd0, slave_interrupt}, 8'd0);
    step(1);
    check("oneshot_irq_e6", {7'd0, slave_interrupt}, 8'd1);
    rdreg(8'd0, 8'h04, "oneshot_ie_ctrl");

    // Reset during the ack cycle of a CTRL write
    wr(8'd4, 8'h01);
    hba_rnw    = 1'b0;
    hba_abus   = 12'h000;
    hba_dbus   = 8'h01;
    hba_select = 1'b1;
    step(1);
    check("ack_before_rst", {7'd0, hba_xferack_slave}, 8'd1);
    hba_reset = 1'b0;
    #1;
    check("ack_async_drop", {7'd0, hba_xferack_slave}, 8'd0);
    hba_select = 1'b0;
    step(1);
    hba_reset = 1'b1;
    rdreg(8'd0, 8'h00, "ctrl_after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
